// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - operand sequencer driving one DSP48A1 multiply-accumulate slice
module dsp_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              sub,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [17:0]       in_a,
    input  logic [17:0]       in_b,
    output logic [17:0]       dsp_a,
    output logic [17:0]       dsp_b,
    output logic [7:0]        dsp_opmode,
    input  logic [47:0]       dsp_p,
    output logic [47:0]       result,
    output logic              result_valid
);

    localparam logic [7:0]       OPM_FIRST = 8'h01;
    localparam logic [7:0]       OPM_NEXT  = 8'h09;
    localparam logic [7:0]       OPM_HOLD  = 8'h08;
    localparam logic [LEN_W-1:0] CNT_ONE   = LEN_W'(1);
    localparam logic [1:0]       DRAIN_CYC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len_q;
    logic              r_sub_q;
    logic [1:0]        r_drain;
    logic              r_busy;
    logic [47:0]       r_result;
    logic              r_result_valid;
    logic [7:0]        r_opmode;

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_first;
    logic              w_last;

    // Operands go straight to the DSP A/B pins; its A1/B1 registers do the capture.
    assign dsp_a = in_a;
    assign dsp_b = in_b;

    assign w_in_ready = (r_state == S_ACCUM) && (r_cnt < r_len_q);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == (r_len_q - CNT_ONE));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_len_q        <= '0;
            r_sub_q        <= 1'b0;
            r_drain        <= 2'd0;
            r_busy         <= 1'b0;
            r_result       <= 48'd0;
            r_result_valid <= 1'b0;
            r_opmode       <= OPM_HOLD;
        end else begin
            r_result_valid <= 1'b0;
            r_opmode       <= OPM_HOLD;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_len_q <= len;
                            r_sub_q <= sub;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_ACCUM;
                        end else begin
                            r_result       <= 48'd0;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        // First term uses Z=0 so a previous job's P never leaks in.
                        r_opmode <= {r_sub_q, 7'b0} | (w_first ? OPM_FIRST : OPM_NEXT);
                        r_cnt    <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_drain <= DRAIN_CYC;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Covers the DSP M and P register stages after the last term.
                    if (r_drain == 2'd0) begin
                        r_result       <= dsp_p;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        r_drain <= r_drain - 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign in_ready     = w_in_ready;
    assign dsp_opmode   = r_opmode;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
